// File: rtl/operand_fetch.sv
// Operand fetch: hides the register file's one-cycle registered read and forwards writebacks.
// Optional stall counter port of_stall_cnt is built when OF_PERF_CNT_EN is defined.
module operand_fetch #(
  parameter int XLEN      = 64,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic [PAYLOAD_W-1:0] id_payload,
  output logic [4:0]           rf_r_reg1,
  output logic [4:0]           rf_r_reg2,
  input  logic [XLEN-1:0]      rf_r_data1,
  input  logic [XLEN-1:0]      rf_r_data2,
  input  logic                 wb_en,
  input  logic [4:0]           wb_reg,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 of_valid,
  input  logic                 of_ready,
  output logic [XLEN-1:0]      of_rs1_data,
  output logic [XLEN-1:0]      of_rs2_data,
  output logic [PAYLOAD_W-1:0] of_payload
`ifdef OF_PERF_CNT_EN
  ,
  output logic [31:0]          of_stall_cnt
`endif
);

  logic                 s1_valid_reg;
  logic [PAYLOAD_W-1:0] s1_payload_reg;
  logic                 of_valid_reg;
  logic [PAYLOAD_W-1:0] of_payload_reg;

  logic s2_take;
  logic id_fire;
  logic s1_hold;
  logic s2_stall;

  logic [4:0]      id_idx  [2];
  logic [4:0]      rd_addr [2];
  logic [XLEN-1:0] rd_data [2];
  logic [XLEN-1:0] op_data [2];

  assign s2_take  = s1_valid_reg && (!of_valid_reg || of_ready);
  assign id_ready = !s1_valid_reg || s2_take;
  assign id_fire  = id_valid && id_ready;
  assign s1_hold  = s1_valid_reg && !s2_take;
  assign s2_stall = of_valid_reg && !of_ready;

  assign id_idx[0]  = id_rs1;
  assign id_idx[1]  = id_rs2;
  assign rd_data[0] = rf_r_data1;
  assign rd_data[1] = rf_r_data2;
  assign rf_r_reg1  = rd_addr[0];
  assign rf_r_reg2  = rd_addr[1];

  assign of_valid    = of_valid_reg;
  assign of_payload  = of_payload_reg;
  assign of_rs1_data = op_data[0];
  assign of_rs2_data = op_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [4:0]      s1_idx_reg;
      logic            byp_flag_reg;
      logic [XLEN-1:0] byp_data_reg;
      logic [4:0]      s2_idx_reg;
      logic [XLEN-1:0] s2_data_reg;
      logic            wb_hit;
      logic [XLEN-1:0] s1_op;

      // The file's read at this edge misses a write on the same edge, so capture it here.
      assign rd_addr[gi] = id_fire ? id_idx[gi] : s1_idx_reg;
      assign wb_hit      = wb_en && (wb_reg == rd_addr[gi]) && (rd_addr[gi] != 5'd0);
      assign s1_op       = (s1_idx_reg == 5'd0) ? '0 :
                           (byp_flag_reg ? byp_data_reg : rd_data[gi]);
      assign op_data[gi] = s2_data_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s1_idx_reg   <= 5'd0;
          byp_flag_reg <= 1'b0;
          byp_data_reg <= '0;
        end else begin
          if (id_fire)
            s1_idx_reg <= id_idx[gi];
          if (id_fire || s1_hold) begin
            byp_flag_reg <= wb_hit;
            if (wb_hit)
              byp_data_reg <= wb_data;
          end
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s2_idx_reg  <= 5'd0;
          s2_data_reg <= '0;
        end else if (s2_take) begin
          s2_idx_reg  <= s1_idx_reg;
          s2_data_reg <= s1_op;
        end else if (s2_stall && wb_en && (wb_reg == s2_idx_reg) && (s2_idx_reg != 5'd0)) begin
          s2_data_reg <= wb_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_reg   <= 1'b0;
      s1_payload_reg <= '0;
      of_valid_reg   <= 1'b0;
      of_payload_reg <= '0;
    end else begin
      if (id_fire) begin
        s1_valid_reg   <= 1'b1;
        s1_payload_reg <= id_payload;
      end else if (s2_take) begin
        s1_valid_reg <= 1'b0;
      end

      if (s2_take) begin
        of_valid_reg   <= 1'b1;
        of_payload_reg <= s1_payload_reg;
      end else if (of_valid_reg && of_ready) begin
        of_valid_reg <= 1'b0;
      end
    end
  end

`ifdef OF_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt_reg <= 32'd0;
    else if (s2_stall && (stall_cnt_reg != 32'hFFFF_FFFF))
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign of_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: behavioural register file, directed vectors,
// stall/reset sequences and a randomized scoreboard run.
module tb_operand_fetch;
  localparam int XLEN = 64;
  localparam int PW   = 32;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            id_valid = 1'b0;
  logic            id_ready;
  logic [4:0]      id_rs1 = 5'd0;
  logic [4:0]      id_rs2 = 5'd0;
  logic [PW-1:0]   id_payload = '0;
  logic [4:0]      rf_r_reg1, rf_r_reg2;
  logic [XLEN-1:0] rf_r_data1, rf_r_data2;
  logic            wb_en = 1'b0;
  logic [4:0]      wb_reg = 5'd0;
  logic [XLEN-1:0] wb_data = '0;
  logic            of_valid;
  logic            of_ready = 1'b0;
  logic [XLEN-1:0] of_rs1_data, of_rs2_data;
  logic [PW-1:0]   of_payload;
`ifdef OF_PERF_CNT_EN
  logic [31:0]     of_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_payload(id_payload),
    .rf_r_reg1(rf_r_reg1), .rf_r_reg2(rf_r_reg2),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .of_valid(of_valid), .of_ready(of_ready),
    .of_rs1_data(of_rs1_data), .of_rs2_data(of_rs2_data),
    .of_payload(of_payload)
`ifdef OF_PERF_CNT_EN
    , .of_stall_cnt(of_stall_cnt)
`endif
  );

  // 32x64 register file: registered read ports, x0 writes ignored
  logic [XLEN-1:0] rf_mem [32];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      rf_r_data1 <= '0;
      rf_r_data2 <= '0;
    end else begin
      rf_r_data1 <= rf_mem[rf_r_reg1];
      rf_r_data2 <= rf_mem[rf_r_reg2];
      if (wb_en && wb_reg != 5'd0) rf_mem[wb_reg] <= wb_data;
    end
  end

  logic [XLEN-1:0] ref_rf [32];

  typedef struct {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            wen;
    logic [4:0]      wreg;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] exp1;
    logic [XLEN-1:0] exp2;
  } vec_t;

  typedef struct {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [PW-1:0]   pay;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: the reference model sees the same writeback as the file, then return at negedge.
  task automatic cycle();
    @(posedge clk);
    if (wb_en && wb_reg != 5'd0) ref_rf[wb_reg] = wb_data;
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [XLEN-1:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    cycle();
    wb_en = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                         input logic [PW-1:0] ep);
    chk({tag, "_valid"}, {63'd0, of_valid}, 64'd1);
    chk({tag, "_rs1"}, of_rs1_data, e1);
    chk({tag, "_rs2"}, of_rs2_data, e2);
    chk({tag, "_payload"}, {32'd0, of_payload}, {32'd0, ep});
    $display("txn %s: rs1=%h rs2=%h payload=%h", tag, of_rs1_data, of_rs2_data, of_payload);
  endtask

  initial begin
    exp_t e;
    logic [PW-1:0] pay_ctr;

    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    vecs[0] = '{5'd5,  5'd6,  1'b0, 5'd0,  64'h0,      64'h11,     64'h22};
    vecs[1] = '{5'd7,  5'd5,  1'b1, 5'd7,  64'hDEAD,   64'hDEAD,   64'h11};
    vecs[2] = '{5'd0,  5'd6,  1'b1, 5'd0,  64'hFF,     64'h0,      64'h22};
    vecs[3] = '{5'd9,  5'd9,  1'b1, 5'd9,  64'h1234,   64'h1234,   64'h1234};
    vecs[4] = '{5'd7,  5'd0,  1'b0, 5'd0,  64'h0,      64'hDEAD,   64'h0};
    vecs[5] = '{5'd6,  5'd5,  1'b1, 5'd5,  64'h55,     64'h22,     64'h55};
    vecs[6] = '{5'd31, 5'd1,  1'b1, 5'd31, {64{1'b1}}, {64{1'b1}}, 64'h0};
    vecs[7] = '{5'd5,  5'd31, 1'b0, 5'd0,  64'h0,      64'h55,     {64{1'b1}}};
    vecs[8] = '{5'd6,  5'd7,  1'b1, 5'd9,  64'hAA,     64'h22,     64'hDEAD};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_of_valid", {63'd0, of_valid}, 64'd0);
    chk("rst_id_ready", {63'd0, id_ready}, 64'd1);
    chk("rst_rs1", of_rs1_data, 64'd0);
    chk("rst_payload", {32'd0, of_payload}, 64'd0);
`ifdef OF_PERF_CNT_EN
    chk("rst_stall_cnt", {32'd0, of_stall_cnt}, 64'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    cycle();

    wb_write(5'd5, 64'h11);
    wb_write(5'd6, 64'h22);
    wb_write(5'd7, 64'h70);
    wb_write(5'd9, 64'h90);

    // Back-to-back reads
    of_ready = 1'b1;
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd6; id_payload = 32'hB0;
    cycle();
    id_rs1 = 5'd6; id_rs2 = 5'd5; id_payload = 32'hB1;
    #1;
    chk("b2b_id_ready", {63'd0, id_ready}, 64'd1);
    cycle();
    id_valid = 1'b0;
    #1;
    chk_out("b2b_0", 64'h11, 64'h22, 32'hB0);
    cycle();
    chk_out("b2b_1", 64'h22, 64'h11, 32'hB1);
    cycle();
    chk("b2b_empty", {63'd0, of_valid}, 64'd0);

    // Directed vectors, one instruction at a time
    for (int i = 0; i < 9; i++) begin
      id_valid = 1'b1; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_payload = 32'hA000_0000 + i;
      wb_en = vecs[i].wen; wb_reg = vecs[i].wreg; wb_data = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_id_ready", i), {63'd0, id_ready}, 64'd1);
      cycle();
      id_valid = 1'b0; wb_en = 1'b0;
      cycle();
      chk_out($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp2, 32'hA000_0000 + i);
      cycle();
      chk($sformatf("vec%0d_drained", i), {63'd0, of_valid}, 64'd0);
    end

    // Stall with S1 and S2 full and a write to a held source
    of_ready = 1'b0;
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd9; id_payload = 32'hC1;
    #1;
    chk("stall_acc1", {63'd0, id_ready}, 64'd1);
    cycle();
    id_rs1 = 5'd9; id_rs2 = 5'd6; id_payload = 32'hC2;
    #1;
    chk("stall_acc2", {63'd0, id_ready}, 64'd1);
    cycle();
    id_valid = 1'b0;
    wb_en = 1'b1; wb_reg = 5'd9; wb_data = 64'h99;
    #1;
    chk("stall_id_ready_0", {63'd0, id_ready}, 64'd0);
    cycle();
    wb_en = 1'b0;
    for (int k = 1; k < 5; k++) begin
      #1;
      chk($sformatf("stall_id_ready_%0d", k), {63'd0, id_ready}, 64'd0);
      cycle();
    end
    of_ready = 1'b1;
    #1;
    chk("stall_release_id_ready", {63'd0, id_ready}, 64'd1);
`ifdef OF_PERF_CNT_EN
    chk("stall_cnt", {32'd0, of_stall_cnt}, 64'd5);
`endif
    chk_out("stall_s2", 64'h55, 64'h99, 32'hC1);
    cycle();
    chk_out("stall_s1", 64'h99, 64'h22, 32'hC2);
    cycle();
    chk("stall_drained", {63'd0, of_valid}, 64'd0);

    // Randomized traffic; writes never target sources still in flight
    pay_ctr = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs1     = 5'($urandom_range(0, 31));
      id_rs2     = 5'($urandom_range(0, 31));
      id_payload = pay_ctr;
      of_ready   = ($urandom_range(0, 3) != 0);
      wb_en      = ($urandom_range(0, 1) != 0);
      wb_reg     = 5'($urandom_range(0, 31));
      wb_data    = {$urandom, $urandom};
      foreach (sb[k])
        if (sb[k].rs1 == wb_reg || sb[k].rs2 == wb_reg) wb_en = 1'b0;
      #1;
      if (of_valid && of_ready) begin
        if (sb.size() == 0) begin
          chk("rand_extra_output", {63'd0, of_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk_out("rand", e.d1, e.d2, e.pay);
        end
      end
      if (id_valid && id_ready) begin
        e.rs1 = id_rs1; e.rs2 = id_rs2; e.pay = pay_ctr;
        e.d1 = (id_rs1 == 5'd0) ? 64'd0 : ((wb_en && wb_reg == id_rs1) ? wb_data : ref_rf[id_rs1]);
        e.d2 = (id_rs2 == 5'd0) ? 64'd0 : ((wb_en && wb_reg == id_rs2) ? wb_data : ref_rf[id_rs2]);
        sb.push_back(e);
        pay_ctr++;
      end
      cycle();
    end
    id_valid = 1'b0; wb_en = 1'b0; of_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (of_valid) begin
        if (sb.size() == 0) begin
          chk("rand_extra_output", {63'd0, of_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk_out("rand_drain", e.d1, e.d2, e.pay);
        end
      end
      cycle();
    end
    chk("rand_all_delivered", 64'(sb.size()), 64'd0);

    // Reset mid-operation with both stages full
    of_ready = 1'b0;
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd6; id_payload = 32'hD1;
    cycle();
    id_payload = 32'hD2;
    cycle();
    id_valid = 1'b0;
    #1;
    chk("mid_full", {63'd0, of_valid}, 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_of_valid", {63'd0, of_valid}, 64'd0);
    chk("mid_rst_rs1", of_rs1_data, 64'd0);
    chk("mid_rst_rs2", of_rs2_data, 64'd0);
    chk("mid_rst_payload", {32'd0, of_payload}, 64'd0);
    @(negedge clk);
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    rstn = 1'b1;
    of_ready = 1'b1;
    cycle();
    chk("post_rst_id_ready", {63'd0, id_ready}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("post_rst_idle_%0d", c), {63'd0, of_valid}, 64'd0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side client of the 32x64 register file, which has a registered read port and ignores writes to x0.
- Accepts decoded instructions on a valid/ready handshake and drives the file's two read addresses.
- Absorbs the one-cycle registered-read latency and forwards same-edge writeback data the file cannot return.
- Presents both 64-bit source operands, plus a carried payload, on a registered valid/ready output to execute.

Parameters:
- XLEN, 64, operand and writeback data width.
- PAYLOAD_W, 32, width of opaque per-instruction payload (rd, opcode fields) carried alongside the operands.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset; asynchronous assert, active-low; synchronous deassert provided externally.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  this block accepts; handshake fires when id_valid && id_ready at posedge.
- id_rs1  in  5  source register 1 index.
- id_rs2  in  5  source register 2 index.
- id_payload  in  PAYLOAD_W  carried unmodified to the output.
- rf_r_reg1  out  5  register file read address 1.
- rf_r_reg2  out  5  register file read address 2.
- rf_r_data1  in  XLEN  register file read data 1, valid the cycle after its address is sampled.
- rf_r_data2  in  XLEN  register file read data 2.
- wb_en  in  1  snoop of the register file write enable.
- wb_reg  in  5  snoop of the write index.
- wb_data  in  XLEN  snoop of the write data.
- of_valid  out  1  operands valid to execute.
- of_ready  in  1  execute accepts.
- of_rs1_data  out  XLEN  operand 1.
- of_rs2_data  out  XLEN  operand 2.
- of_payload  out  PAYLOAD_W  carried payload.
- of_stall_cnt  out  32  present only with OF_PERF_CNT_EN.

Behaviour:
- Two stages:
  - S1 holds the accepted instruction while the register file read is outstanding.
  - S2 is the output register.
- Reset (rstn=0, asynchronous):
  - s1_valid=0, of_valid=0.
  - of_rs1_data, of_rs2_data, of_payload = 0.
  - S1 bypass flags = 0.
  - of_stall_cnt = 0.
- Handshake and control:
  - s2_take = s1_valid && (!of_valid || of_ready).
  - id_ready = !s1_valid || s2_take. id_ready is combinational and does not depend on id_valid.
- Read address:
  - rf_r_reg1/2 = id_rs1/2 when id_valid && id_ready; otherwise s1_rs1/2.
  - While S1 holds, the file re-reads the same registers every cycle.
- Bypass capture, every posedge where S1 loads or holds. For each source with sampled index A:
  - If wb_en && wb_reg==A && A!=0: flag=1, byp_data=wb_data.
  - Otherwise flag=0, because the re-read now reflects all earlier writes.
- S1 operand value:
  - x0 (index 0): value is 0.
  - Else if flag is set: byp_data.
  - Else: rf_r_data.
- S2 load: on s2_take, S2 captures the S1 operand values, the payload and the indices; of_valid=1.
- S2 clear: if of_valid && of_ready && !s2_take, of_valid=0.
- S2 snoop while of_valid && !of_ready: if wb_en && wb_reg matches a held nonzero index, that operand is updated to wb_data.
- Latency and throughput:
  - Latency is 2 cycles: id handshake at edge E0 gives of_valid=1 after edge E1, provided S2 is empty or draining.
  - Full throughput is 1 instruction per cycle.
- Boundary conditions:
  - rs1==rs2: both operands get the identical forwarded value.
  - wb_reg==0: never forwarded.
  - of_ready held low for N cycles: no instruction lost or duplicated. S1 and S2 both hold, and id_ready=0 until S2 drains.
  - Reset mid-operation: all in-flight instructions discarded; no output until a new accept.

Optional Feature:
- OF_PERF_CNT_EN defined:
  - of_stall_cnt increments each cycle with of_valid && !of_ready.
  - Saturates at 0xFFFFFFFF; reset to 0.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: rstn low mid-stream, then released -> of_valid=0, outputs=0, id_ready=1 the cycle after release.
- Back-to-back reads: file preloaded x5=0x11, x6=0x22; issue (5,6),(6,5) on consecutive cycles with of_ready=1 -> of_valid for 2 consecutive cycles, operands 0x11/0x22 then 0x22/0x11.
- Same-edge forward: accept rs1=7 on the same edge as wb_en=1, wb_reg=7, wb_data=0xDEAD -> of_rs1_data=0xDEAD, although the file returned the old value.
- x0 forwarding: rs1=0 while wb_en=1, wb_reg=0, wb_data=0xFF -> of_rs1_data=0.
- Stall with write: of_ready=0 for 5 cycles with S1 and S2 both full.
  - A write x9=0x99 during the stall, with S2 rs2=9 and S1 rs1=9 -> both read 0x99 on drain.
  - id_ready=0 throughout; of_stall_cnt=5 when OF_PERF_CNT_EN is defined.
- Randomized valid/ready plus random writebacks against a reference register model -> every output operand equals the model value at issue time; no drops or duplicates.
